// File: rtl/pes_bdi_line_packer.sv
// BDI line packer: header byte plus right-aligned payload per line,
// concatenated into a 64-bit word stream with a zero-padded flush drain.
module pes_bdi_line_packer (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_encoding,
    input  logic [255:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [3:0]   out_bytes,
    output logic [15:0]  lines_packed
);

    logic [319:0] buffer;
    logic [5:0]   cnt;
    logic         flush_pending;

    logic [5:0]   len;
    logic [255:0] pay_mask;
    logic [263:0] record;
    logic [319:0] placed;
    logic         accept;
    logic         emit;
    logic [5:0]   cnt_next;
    logic         fp_next;
    logic [63:0]  out_mask;

    always_comb begin
        len = 6'd0;
        unique case (in_encoding)
            3'd0: len = 6'd0;
            3'd1: len = 6'd12;
            3'd2: len = 6'd16;
            3'd3: len = 6'd24;
            3'd4: len = 6'd12;
            3'd5: len = 6'd20;
            3'd6: len = 6'd18;
            3'd7: len = 6'd32;
        endcase
    end

    // Masking the payload keeps every buffer byte at index >= cnt zero.
    assign pay_mask = (256'd1 << {len, 3'b000}) - 256'd1;
    assign record   = {in_data & pay_mask, 5'b00000, in_encoding};
    assign placed   = {56'd0, record} << {cnt, 3'b000};

    assign in_ready  = (cnt <= 6'd7) && !flush_pending;
    assign out_valid = (cnt >= 6'd8) || (flush_pending && cnt != 6'd0);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        cnt_next = cnt;
        if (accept)
            cnt_next = cnt + len + 6'd1;
        else if (emit)
            cnt_next = (cnt >= 6'd8) ? cnt - 6'd8 : 6'd0;
    end

    // A pending flush with nothing left to drain would stall the input.
    assign fp_next = (flush_pending || (flush && (cnt != 6'd0 || accept)))
                     && (cnt_next != 6'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer        <= '0;
            cnt           <= 6'd0;
            flush_pending <= 1'b0;
            lines_packed  <= 16'd0;
        end else begin
            if (accept)
                buffer <= buffer | placed;
            else if (emit)
                buffer <= buffer >> 64;
            cnt           <= cnt_next;
            flush_pending <= fp_next;
            if (accept)
                lines_packed <= lines_packed + 16'd1;
        end
    end

    assign out_mask  = (cnt >= 6'd8) ? {64{1'b1}}
                     : ((64'd1 << {cnt[2:0], 3'b000}) - 64'd1);
    assign out_data  = buffer[63:0] & out_mask;
    assign out_bytes = (cnt >= 6'd8) ? 4'd8 : {1'b0, cnt[2:0]};

endmodule

// File: tb/tb_pes_bdi_line_packer.sv
// Directed bench for pes_bdi_line_packer: reset, stream packing,
// concatenation across lines, backpressure and flush behaviour.
module tb_pes_bdi_line_packer;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_encoding;
    logic [255:0] in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [3:0]   out_bytes;
    logic [15:0]  lines_packed;

    int checks = 0;
    int failures = 0;
    logic [67:0] words[$];

    pes_bdi_line_packer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_encoding(in_encoding), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bytes(out_bytes),
        .lines_packed(lines_packed)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (!reset && out_valid && out_ready)
            words.push_back({out_bytes, out_data});

    function automatic logic [255:0] ramp(input logic [7:0] base, input int n);
        logic [255:0] d;
        for (int k = 0; k < 32; k++)
            d[8*k +: 8] = (k < n) ? base + 8'(k) : 8'hEE;
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        words.delete();
    endtask

    task automatic accept_line(input logic [2:0] enc, input logic [255:0] d,
                               input logic fl);
        int n = 0;
        in_valid = 1'b1;
        in_encoding = enc;
        in_data = d;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got in_ready=%b want 1", in_ready);
        end
        flush = fl;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [63:0] d,
                               input logic [3:0] b);
        logic [67:0] w;
        checks++;
        if (words.size() == 0) begin
            failures++;
            $display("FAIL %s got no word want %h/%0d", name, d, b);
        end else begin
            w = words.pop_front();
            if (w !== {b, d}) begin
                failures++;
                $display("FAIL %s got %h/%0d want %h/%0d",
                         name, w[63:0], w[67:64], d, b);
            end
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        checks++;
        if ({out_valid, in_ready, lines_packed, out_bytes, out_data} !==
            {1'b0, 1'b1, 16'd0, 4'd0, 64'd0}) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%b n=%0d b=%0d d=%h",
                     out_valid, in_ready, lines_packed, out_bytes, out_data);
        end
        for (int i = 0; i < 5; i++)
            accept_line(3'd0, '0, 1'b0);
        pulse_flush();
        checks++;
        if (out_valid !== 1'b1 || out_bytes !== 4'd5) begin
            failures++;
            $display("FAIL pre_reset got v=%b b=%0d want 1/5",
                     out_valid, out_bytes);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_bytes, in_ready, lines_packed} !==
            {1'b0, 4'd0, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL async_reset got v=%b b=%0d r=%b n=%0d",
                     out_valid, out_bytes, in_ready, lines_packed);
        end
        do_reset();
    endtask

    task automatic test_enc0_run();
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++)
            accept_line(3'd0, ramp(8'h55, 32), 1'b0);
        checks++;
        if ({out_valid, out_data, out_bytes, in_ready, lines_packed} !==
            {1'b1, 64'd0, 4'd8, 1'b0, 16'd8}) begin
            failures++;
            $display("FAIL enc0_word got v=%b d=%h b=%0d r=%b n=%0d",
                     out_valid, out_data, out_bytes, in_ready, lines_packed);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL enc0_after got v=%b r=%b want 0/1",
                     out_valid, in_ready);
        end
        expect_word("enc0_stream", 64'd0, 4'd8);
    endtask

    task automatic test_uncompressed();
        out_ready = 1'b1;
        do_reset();
        accept_line(3'd7, ramp(8'h01, 32), 1'b0);
        tick(); tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || words.size() != 3) begin
            failures++;
            $display("FAIL enc7_3cyc got r=%b words=%0d want 0/3",
                     in_ready, words.size());
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL enc7_4cyc got r=%b v=%b want 1/0",
                     in_ready, out_valid);
        end
        expect_word("enc7_w0", 64'h0706_0504_0302_0107, 4'd8);
        expect_word("enc7_w1", 64'h0F0E_0D0C_0B0A_0908, 4'd8);
        expect_word("enc7_w2", 64'h1716_1514_1312_1110, 4'd8);
        expect_word("enc7_w3", 64'h1F1E_1D1C_1B1A_1918, 4'd8);
        pulse_flush();
        checks++;
        if ({out_valid, out_data, out_bytes, in_ready} !==
            {1'b1, 64'h20, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL enc7_flush got v=%b d=%h b=%0d r=%b",
                     out_valid, out_data, out_bytes, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL enc7_drained got v=%b r=%b want 0/1",
                     out_valid, in_ready);
        end
        expect_word("enc7_w4", 64'h20, 4'd1);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_reset();
        accept_line(3'd1, ramp(8'hA0, 12), 1'b0);
        accept_line(3'd4, ramp(8'hB0, 12), 1'b0);
        tick(); tick(); tick();
        checks++;
        if (lines_packed !== 16'd2 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_state got n=%0d v=%b want 2/0",
                     lines_packed, out_valid);
        end
        expect_word("b2b_w0", 64'hA6A5_A4A3_A2A1_A001, 4'd8);
        expect_word("b2b_w1", 64'hB1B0_04AB_AAA9_A8A7, 4'd8);
        expect_word("b2b_w2", 64'hB9B8_B7B6_B5B4_B3B2, 4'd8);
        pulse_flush();
        tick();
        expect_word("b2b_tail", 64'hBBBA, 4'd2);
    endtask

    task automatic test_backpressure();
        logic [63:0] held_d;
        logic [3:0]  held_b;
        out_ready = 1'b0;
        do_reset();
        accept_line(3'd7, ramp(8'h01, 32), 1'b0);
        held_d = out_data;
        held_b = out_bytes;
        checks++;
        if (held_d !== 64'h0706_0504_0302_0107 || held_b !== 4'd8) begin
            failures++;
            $display("FAIL bp_first got %h/%0d", held_d, held_b);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid, out_data, out_bytes, in_ready} !==
                {1'b1, held_d, held_b, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b d=%h b=%0d r=%b",
                         i, out_valid, out_data, out_bytes, in_ready);
            end
        end
        out_ready = 1'b1;
        repeat (5) tick();
        expect_word("bp_w0", 64'h0706_0504_0302_0107, 4'd8);
        expect_word("bp_w1", 64'h0F0E_0D0C_0B0A_0908, 4'd8);
        expect_word("bp_w2", 64'h1716_1514_1312_1110, 4'd8);
        expect_word("bp_w3", 64'h1F1E_1D1C_1B1A_1918, 4'd8);
        checks++;
        if (words.size() != 0) begin
            failures++;
            $display("FAIL bp_extra got %0d words want 0", words.size());
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        do_reset();
        pulse_flush();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || words.size() != 0) begin
            failures++;
            $display("FAIL flush_empty got v=%b r=%b words=%0d",
                     out_valid, in_ready, words.size());
        end
        accept_line(3'd2, ramp(8'hC0, 16), 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL flush_busy%0d got r=%b want 0", i, in_ready);
            end
            tick();
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_done got r=%b v=%b want 1/0",
                     in_ready, out_valid);
        end
        expect_word("flush_w0", 64'hC6C5_C4C3_C2C1_C002, 4'd8);
        expect_word("flush_w1", 64'hCECD_CCCB_CAC9_C8C7, 4'd8);
        expect_word("flush_w2", 64'hCF, 4'd1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_encoding = 3'd0;
        in_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_enc0_run();
        test_uncompressed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
